// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;

  // CLEAR zeroes the array one entry per cycle; RUN accepts writes.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_if.sv
// Bus bundle for regfile_mp: write ports, flattened read lanes, debug tap and status.
interface regfile_if import regfile_pkg::*; #(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF
);
  localparam int AW = $clog2(NREGS);

  logic                 we0;
  logic                 we1;
  logic [AW-1:0]        wa0;
  logic [AW-1:0]        wa1;
  logic [XLEN-1:0]      wd0;
  logic [XLEN-1:0]      wd1;
  logic [NRD*AW-1:0]    ra;
  logic [NRD*XLEN-1:0]  rd;
  logic [AW-1:0]        dbg_sel;
  logic [XLEN-1:0]      dbg_data;
  logic                 ready;
  logic                 wr_collision;

  modport master (
    output we0, we1, wa0, wa1, wd0, wd1, ra, dbg_sel,
    input  rd, dbg_data, ready, wr_collision
  );

  modport slave (
    input  we0, we1, wa0, wa1, wd0, wd1, ra, dbg_sel,
    output rd, dbg_data, ready, wr_collision
  );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read lane: array select with x0 and CLEAR masking.
// With REGFILE_BYPASS_EN defined, a same-cycle write to the read address is
// forwarded, port 1 taking priority over port 0.
module regfile_rd_port import regfile_pkg::*; #(
  parameter int  XLEN  = XLEN_DEF,
  parameter int  NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic [NREGS-1:0][XLEN-1:0] mem,
  input  logic                       run,
  input  logic [AW-1:0]              ra,
`ifdef REGFILE_BYPASS_EN
  input  logic                       wen0,
  input  logic [AW-1:0]              wa0,
  input  logic [XLEN-1:0]            wd0,
  input  logic                       wen1,
  input  logic [AW-1:0]              wa1,
  input  logic [XLEN-1:0]            wd1,
`endif
  output logic [XLEN-1:0]            rd
);

  // Lane select: masked during the sweep and for x0, optionally forwarded
  always_comb begin
    rd = {XLEN{1'b0}};
    if (!run) begin
      rd = {XLEN{1'b0}};
    end else if (ra == {AW{1'b0}}) begin
      rd = {XLEN{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (wen1 && (wa1 == ra)) begin
      rd = wd1;
    end else if (wen0 && (wa0 == ra)) begin
      rd = wd0;
`endif
    end else begin
      rd = mem[ra];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: 2 write ports, NRD combinational read lanes,
// debug tap, self-clearing sweep after reset and same-address write flag.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
module regfile_mp import regfile_pkg::*; #(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  state_e                      state_r;
  logic [AW-1:0]               ptr_r;
  logic                        ready_r;
  logic                        coll_r;
  logic [NREGS-1:0][XLEN-1:0]  mem_r;

  logic                        wen0_s;
  logic                        wen1_s;
  logic                        coll_s;
  logic [NRD*XLEN-1:0]         rd_s;
  logic [XLEN-1:0]             dbg_s;

  // Effective write enables: writes to x0 never reach the array
  always_comb begin
    wen0_s = bus.we0 && (bus.wa0 != {AW{1'b0}});
    wen1_s = bus.we1 && (bus.wa1 != {AW{1'b0}});
    coll_s = wen0_s && wen1_s && (bus.wa0 == bus.wa1);
  end

  // Sweep/run sequencer with registered ready and collision pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CLEAR;
      ptr_r   <= {AW{1'b0}};
      ready_r <= 1'b0;
      coll_r  <= 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          coll_r <= 1'b0;
          if (ptr_r == AW'(NREGS - 1)) begin
            state_r <= RUN;
            ready_r <= 1'b1;
            ptr_r   <= {AW{1'b0}};
          end else begin
            state_r <= CLEAR;
            ready_r <= 1'b0;
            ptr_r   <= ptr_r + AW'(1);
          end
        end
        RUN: begin
          state_r <= RUN;
          ready_r <= 1'b1;
          coll_r  <= coll_s;
        end
        default: begin
          state_r <= CLEAR;
          ptr_r   <= {AW{1'b0}};
          ready_r <= 1'b0;
          coll_r  <= 1'b0;
        end
      endcase
    end
  end

  // Array update: sweep zeroes in CLEAR; port 1 is written last so it wins ties
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_r == CLEAR) begin
        mem_r[ptr_r] <= {XLEN{1'b0}};
      end else begin
        if (wen0_s) begin
          mem_r[bus.wa0] <= bus.wd0;
        end
        if (wen1_s) begin
          mem_r[bus.wa1] <= bus.wd1;
        end
      end
    end
  end

  // One read lane per port
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rd_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
    ) u_rd (
      .mem  (mem_r),
      .run  (ready_r),
      .ra   (bus.ra[k*AW +: AW]),
`ifdef REGFILE_BYPASS_EN
      .wen0 (wen0_s),
      .wa0  (bus.wa0),
      .wd0  (bus.wd0),
      .wen1 (wen1_s),
      .wa1  (bus.wa1),
      .wd1  (bus.wd1),
`endif
      .rd   (rd_s[k*XLEN +: XLEN])
    );
  end

  // Debug tap shows stored contents only, never forwarded data
  always_comb begin
    dbg_s = {XLEN{1'b0}};
    if (!ready_r) begin
      dbg_s = {XLEN{1'b0}};
    end else if (bus.dbg_sel == {AW{1'b0}}) begin
      dbg_s = {XLEN{1'b0}};
    end else begin
      dbg_s = mem_r[bus.dbg_sel];
    end
  end

  assign bus.rd           = rd_s;
  assign bus.dbg_data     = dbg_s;
  assign bus.ready        = ready_r;
  assign bus.wr_collision = coll_r;

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
- REQ-001 SHALL have parameter XLEN, default 32: register width in bits.
- REQ-002 SHALL have parameter NREGS, default 32: register count, power of two, at least 4; AW = clog2(NREGS).
- REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1 to 4.
- REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
- REQ-006 SHALL have ports we0/we1, input, 1 bit each: write enables, write ports 0 and 1.
- REQ-007 SHALL have ports wa0/wa1, input, AW bits each: write addresses.
- REQ-008 SHALL have ports wd0/wd1, input, XLEN bits each: write data.
- REQ-009 SHALL have port ra, input, NRD*AW bits: flattened read addresses; port k occupies bits [k*AW +: AW].
- REQ-010 SHALL have port rd, output, NRD*XLEN bits: flattened read data; port k occupies bits [k*XLEN +: XLEN].
- REQ-011 SHALL have port dbg_sel, input, AW bits: debug tap address.
- REQ-012 SHALL have port dbg_data, output, XLEN bits: stored value at dbg_sel, never bypassed.
- REQ-013 SHALL have port ready, output, 1 bit: high when the clear sweep is done and writes are accepted.
- REQ-014 SHALL have port wr_collision, output, 1 bit: registered one-cycle pulse flagging a same-address dual write.

Function
- REQ-015 SHALL implement a two-state FSM: CLEAR and RUN. ready SHALL equal (state == RUN).
- REQ-016 In CLEAR with rst low, each rising edge SHALL write 0 to mem[ptr] and increment ptr.
- REQ-017 The FSM SHALL leave CLEAR when ptr == NREGS-1 is cleared, so ready rises exactly NREGS cycles after rst deasserts.
- REQ-018 In CLEAR, the bench SHALL see writes ignored and every rd lane and dbg_data read as 0.
- REQ-019 In RUN, a write port with we=1 and a nonzero address SHALL update mem[wa] at the rising edge.
- REQ-020 Writes to address 0 SHALL be discarded; reads of address 0 SHALL always return 0.
- REQ-021 When both ports write the same nonzero address in the same cycle, port 1 data SHALL be stored.
- REQ-022 In the same-address case of REQ-021, wr_collision SHALL be 1 on the following cycle only.
- REQ-023 Reads SHALL be combinational from ra (zero-cycle latency); writes SHALL become visible from the next cycle.
- REQ-024 Read ports SHALL be independent; identical addresses on several ports SHALL return identical data.

Reset
- REQ-025 While rst is high: state = CLEAR, ptr = 0, wr_collision = 0, ready = 0, no array writes.
- REQ-026 rst asserted in RUN SHALL restart the full sweep; contents are undefined until ready rises again.
- REQ-027 rst asserted mid-sweep SHALL restart the sweep at ptr = 0.

Configuration
- REQ-028 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
- REQ-029 With REGFILE_BYPASS_EN defined, in RUN a read of nonzero address A written this cycle SHALL return the incoming write data.
- REQ-030 Under REQ-029, if both write ports target A, the forwarded data SHALL be port 1's.
- REQ-031 Without REGFILE_BYPASS_EN, reads SHALL return the stored (pre-write) value.
- REQ-032 dbg_data SHALL be unaffected by REGFILE_BYPASS_EN.

Structure
- REQ-033 Package regfile_pkg SHALL hold the FSM state enum (CLEAR, RUN) and the default XLEN/NREGS/NRD constants.
- REQ-034 Sub-module regfile_rd_port SHALL implement one read lane: array select, x0 masking, CLEAR masking and optional bypass.
- REQ-035 regfile_rd_port SHALL be instantiated NRD times by a generate loop.

Verification (XLEN=32, NREGS=32, NRD=2)
- REQ-036 Pulse rst 1 cycle, drive writes throughout: ready rises 32 cycles after rst falls; all 32 registers read 0.
- REQ-037 RUN, we0=1 wa0=5 wd0=0xDEADBEEF, ra0=5: next cycle rd lane0 = 0xDEADBEEF.
- REQ-038 Same cycle as REQ-037: lane0 = 0xDEADBEEF with REGFILE_BYPASS_EN defined, else the old value.
- REQ-039 we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22: mem[7]=0x22; wr_collision=1 for exactly one cycle.
- REQ-040 we1=1 wa1=0 wd1=0xFFFFFFFF: ra=0 returns 0 on both lanes and dbg_sel=0 returns 0; wr_collision stays 0.
- REQ-041 Write 0x5A to reg 19, then assert rst at sweep ptr=10: sweep restarts, ready rises 32 cycles after rst falls, dbg_sel=19 returns 0.
